// File: rtl/apb_pkg.sv
// Shared APB definitions: bus-phase state encoding, default geometry and
// the select-vector helper used by the peripheral slave.
package apb_pkg;

    localparam int DATA_W      = 32;
    localparam int ADDR_W      = 32;
    localparam int DEF_NUM_SLV = 4;
    localparam int DEF_DEPTH   = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_state_e;

    // True when exactly one bit of the (zero-extended) select vector is set.
    function automatic logic is_onehot(input logic [DATA_W-1:0] v);
        return (v != {DATA_W{1'b0}}) && ((v & (v - DATA_W'(1))) == {DATA_W{1'b0}});
    endfunction

endpackage

// File: rtl/apb_slot_mem.sv
// One peripheral slot: DEPTH x DATA_W register file, cleared asynchronously,
// single write port and a combinational read port.
module apb_slot_mem
    import apb_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              we_i,
    input  logic [IDX_W-1:0]  waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [IDX_W-1:0]  raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];

    // Word storage: whole array cleared on reset, one word written per enable.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= {DATA_W{1'b0}};
            end
        end else if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/apb_modport_slave.sv
// Zero-wait-state APB slave fronting NUM_SLV independent register-file slots,
// with a registered read-data port and a sticky protocol-violation flag.
module apb_modport_slave
    import apb_pkg::*;
#(
    parameter int NUM_SLV = DEF_NUM_SLV,
    parameter int DEPTH   = DEF_DEPTH
) (
    input  logic               Pclk,
    input  logic               Presetn,
    input  logic [NUM_SLV-1:0] Pselx,
    input  logic [ADDR_W-1:0]  Paddr,
    input  logic [DATA_W-1:0]  Pwdata,
    input  logic               Penable,
    input  logic               Pwrite,
    output logic [DATA_W-1:0]  Prdata,
    output logic               Perr
);

    localparam int IDX_W = $clog2(DEPTH);

    apb_state_e         state_q, state_d;
    logic [NUM_SLV-1:0] sel_q, sel_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic               write_q, write_d;
    logic [DATA_W-1:0]  wdata_q, wdata_d;
    logic [DATA_W-1:0]  prdata_q, prdata_d;
    logic               perr_q, perr_d;

    logic               sel_any_s;
    logic               sel_onehot_s;
    logic               setup_cycle_s;
    logic               access_cycle_s;
    logic               changed_s;
    logic               viol_s;
    logic               wr_commit_s;
    logic [IDX_W-1:0]   idx_s;
    logic [DATA_W-1:0]  slot_rdata_s [NUM_SLV];
    logic [DATA_W-1:0]  rd_mux_s;

    assign sel_any_s    = (Pselx != {NUM_SLV{1'b0}});
    assign sel_onehot_s = is_onehot(DATA_W'(Pselx));
    assign idx_s        = Paddr[IDX_W+1:2];

    // Bus-phase tracking; IDLE and ACCESS share the same exit rule.
    always_comb begin
        state_d = IDLE;
        case (state_q)
            IDLE: begin
                if (sel_any_s && !Penable) begin
                    state_d = SETUP;
                end else begin
                    state_d = IDLE;
                end
            end
            SETUP: begin
                if (Penable) begin
                    state_d = ACCESS;
                end else begin
                    state_d = IDLE;
                end
            end
            ACCESS: begin
                if (sel_any_s && !Penable) begin
                    state_d = SETUP;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Setup cycle = the cycle whose edge moves the FSM into SETUP; the access
    // cycle is then observed with the FSM already sitting in SETUP.
    assign setup_cycle_s  = (state_q != SETUP) && sel_any_s && !Penable;
    assign access_cycle_s = (state_q == SETUP) && Penable;

    assign changed_s = access_cycle_s &&
                       ((Pselx != sel_q) || (Paddr != addr_q) ||
                        (Pwrite != write_q) || (Pwdata != wdata_q));

    assign viol_s = ((state_q == IDLE) && Penable) || changed_s ||
                    (sel_any_s && !sel_onehot_s);

    assign wr_commit_s = access_cycle_s && Pwrite && sel_onehot_s && !viol_s;

    for (genvar g = 0; g < NUM_SLV; g++) begin : g_slot
        apb_slot_mem #(
            .DEPTH (DEPTH),
            .IDX_W (IDX_W)
        ) u_mem (
            .clk_i   (Pclk),
            .rst_n_i (Presetn),
            .we_i    (wr_commit_s & Pselx[g]),
            .waddr_i (idx_s),
            .wdata_i (Pwdata),
            .raddr_i (idx_s),
            .rdata_o (slot_rdata_s[g])
        );
    end

    // AND-OR read mux; only meaningful when the select is one-hot.
    always_comb begin
        rd_mux_s = {DATA_W{1'b0}};
        for (int i = 0; i < NUM_SLV; i++) begin
            rd_mux_s = rd_mux_s | (slot_rdata_s[i] & {DATA_W{Pselx[i]}});
        end
    end

    // Next values for setup capture, read data and the sticky error flag.
    always_comb begin
        sel_d    = sel_q;
        addr_d   = addr_q;
        write_d  = write_q;
        wdata_d  = wdata_q;
        prdata_d = prdata_q;
        perr_d   = perr_q | viol_s;
        if (setup_cycle_s) begin
            sel_d   = Pselx;
            addr_d  = Paddr;
            write_d = Pwrite;
            wdata_d = Pwdata;
            if (!Pwrite) begin
                prdata_d = sel_onehot_s ? rd_mux_s : {DATA_W{1'b0}};
            end else begin
                prdata_d = prdata_q;
            end
        end else begin
            prdata_d = prdata_q;
        end
    end

    // Control and output registers.
    always_ff @(posedge Pclk or negedge Presetn) begin
        if (!Presetn) begin
            state_q  <= IDLE;
            sel_q    <= {NUM_SLV{1'b0}};
            addr_q   <= {ADDR_W{1'b0}};
            write_q  <= 1'b0;
            wdata_q  <= {DATA_W{1'b0}};
            prdata_q <= {DATA_W{1'b0}};
            perr_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            sel_q    <= sel_d;
            addr_q   <= addr_d;
            write_q  <= write_d;
            wdata_q  <= wdata_d;
            prdata_q <= prdata_d;
            perr_q   <= perr_d;
        end
    end

    assign Prdata = prdata_q;
    assign Perr   = perr_q;

endmodule

// File: tb/tb_apb_modport_slave.sv
// Directed bench for apb_modport_slave: expected read data is queued when a
// read is issued and compared when the access phase presents Prdata.
module tb_apb_modport_slave;

    logic        Pclk = 1'b0;
    logic        Presetn;
    logic [3:0]  Pselx;
    logic [31:0] Paddr;
    logic [31:0] Pwdata;
    logic        Penable;
    logic        Pwrite;
    logic [31:0] Prdata;
    logic        Perr;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];
    logic [31:0] d [4];

    apb_modport_slave #(.NUM_SLV(4), .DEPTH(16)) dut (
        .Pclk    (Pclk),
        .Presetn (Presetn),
        .Pselx   (Pselx),
        .Paddr   (Paddr),
        .Pwdata  (Pwdata),
        .Penable (Penable),
        .Pwrite  (Pwrite),
        .Prdata  (Prdata),
        .Perr    (Perr)
    );

    always #5 Pclk = ~Pclk;

    task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic bus_idle();
        Pselx   = 4'b0000;
        Penable = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        bus_idle();
        repeat (n) begin
            @(posedge Pclk); #1;
        end
    endtask

    task automatic apb_write(input logic [3:0] sel, input logic [31:0] addr, input logic [31:0] data);
        Pselx = sel; Paddr = addr; Pwdata = data; Pwrite = 1'b1; Penable = 1'b0;
        @(posedge Pclk); #1;
        Penable = 1'b1;
        @(posedge Pclk); #1;
        bus_idle();
    endtask

    task automatic apb_read(input string tag, input logic [3:0] sel, input logic [31:0] addr, input logic [31:0] exp);
        exp_q.push_back(exp);
        Pselx = sel; Paddr = addr; Pwrite = 1'b0; Penable = 1'b0;
        @(posedge Pclk); #1;
        Penable = 1'b1;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL %s observed=empty expected=entry", tag);
        end else begin
            check32(tag, Prdata, exp_q.pop_front());
        end
        @(posedge Pclk); #1;
        bus_idle();
    endtask

    task automatic reset_pulse();
        Presetn = 1'b0;
        bus_idle();
        @(posedge Pclk); #3;
        Presetn = 1'b1;
    endtask

    initial begin
        Presetn = 1'b0;
        Pselx = 4'b0000; Paddr = 32'h0; Pwdata = 32'h0; Penable = 1'b0; Pwrite = 1'b0;
        #12;
        check32("reset_prdata", Prdata, 32'h0);
        check1("reset_perr", Perr, 1'b0);
        @(posedge Pclk); #3;
        Presetn = 1'b1;

        // write then back-to-back read on slot 1
        apb_write(4'b0010, 32'h8, 32'hDEADBEEF);
        apb_read("wr_rd_slot1", 4'b0010, 32'h8, 32'hDEADBEEF);
        check1("wr_rd_perr", Perr, 1'b0);
        idle_cycles(3);
        check32("prdata_hold", Prdata, 32'hDEADBEEF);

        apb_read("slot_isolation", 4'b0001, 32'h8, 32'h0);

        // address wrap and ignored upper/low address bits
        apb_write(4'b0100, 32'h40, 32'h12345678);
        apb_read("addr_wrap", 4'b0100, 32'h0, 32'h12345678);
        apb_read("addr_upper_ignored", 4'b0100, 32'hFFFFFF43, 32'h12345678);

        for (int i = 0; i < 4; i++) begin
            d[i] = $urandom;
            apb_write(4'b1000, 32'(i * 4 + 32'h100), d[i]);
        end
        for (int i = 0; i < 4; i++) begin
            apb_read("slot3_pattern", 4'b1000, 32'(i * 4), d[i]);
        end
        check1("pattern_perr", Perr, 1'b0);

        // non-one-hot select
        apb_write(4'b0011, 32'h4, 32'hA5A5A5A5);
        check1("multi_sel_perr", Perr, 1'b1);
        apb_read("multi_sel_slot0", 4'b0001, 32'h4, 32'h0);
        apb_read("multi_sel_slot1", 4'b0010, 32'h4, 32'h0);
        apb_read("prep_nonzero", 4'b0100, 32'h0, 32'h12345678);
        apb_read("multi_sel_read_zero", 4'b0011, 32'h0, 32'h0);

        reset_pulse();
        check1("reset2_perr", Perr, 1'b0);
        apb_read("reset_clears_mem", 4'b0100, 32'h0, 32'h0);

        // Penable without setup
        idle_cycles(2);
        Pselx = 4'b0001; Pwrite = 1'b0; Penable = 1'b1;
        @(posedge Pclk); #1;
        check1("penable_idle_perr", Perr, 1'b1);
        idle_cycles(5);
        check1("perr_sticky", Perr, 1'b1);
        reset_pulse();
        check1("perr_cleared", Perr, 1'b0);

        // data changed between setup and access: error, no write
        Pselx = 4'b0001; Paddr = 32'hC; Pwdata = 32'h11111111; Pwrite = 1'b1; Penable = 1'b0;
        @(posedge Pclk); #1;
        Penable = 1'b1; Pwdata = 32'h22222222;
        @(posedge Pclk); #1;
        bus_idle();
        check1("changed_perr", Perr, 1'b1);
        apb_read("changed_no_write", 4'b0001, 32'hC, 32'h0);
        reset_pulse();

        // reset in the middle of a write access phase
        apb_write(4'b0010, 32'h10, 32'h00000001);
        apb_read("pre_abort_value", 4'b0010, 32'h10, 32'h00000001);
        idle_cycles(1);
        Pselx = 4'b0001; Pwrite = 1'b0; Penable = 1'b1;
        @(posedge Pclk); #1;
        check1("pre_abort_perr", Perr, 1'b1);
        Pselx = 4'b0010; Paddr = 32'h10; Pwdata = 32'hCAFEF00D; Pwrite = 1'b1; Penable = 1'b0;
        @(posedge Pclk); #1;
        Penable = 1'b1;
        #2;
        Presetn = 1'b0;
        #1;
        check32("abort_prdata", Prdata, 32'h0);
        check1("abort_perr", Perr, 1'b0);
        @(posedge Pclk); #3;
        bus_idle();
        Presetn = 1'b1;
        apb_read("abort_no_write", 4'b0010, 32'h10, 32'h0);
        check1("final_perr", Perr, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/apb_modport_slave.md
APB_MODPORT_SLAVE -- requirements
Module: apb_modport_slave

Interface
REQ-001 SHALL have parameter NUM_SLV, default 4: number of peripheral slots, one per Pselx bit.
REQ-002 SHALL have parameter DEPTH, default 16: 32-bit words per slot; power of two.
REQ-003 SHALL have the port Pclk, input, 1 bit: the only clock; all state updates on its rising edge.
REQ-004 SHALL have the port Presetn, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have the port Pselx, input, NUM_SLV bits: one-hot peripheral select.
REQ-006 SHALL have the port Paddr, input, 32 bits: byte address.
REQ-007 SHALL have the port Pwdata, input, 32 bits: write data.
REQ-008 SHALL have the port Penable, input, 1 bit: access-phase strobe.
REQ-009 SHALL have the port Pwrite, input, 1 bit: 1 = write, 0 = read.
REQ-010 SHALL have the port Prdata, output, 32 bits: registered read data.
REQ-011 SHALL have the port Perr, output, 1 bit: sticky protocol-violation flag.

Function
REQ-012 SHALL track the bus with a three-state FSM: IDLE, SETUP, ACCESS.
- IDLE->SETUP: Pselx!=0 and Penable=0.
- SETUP->ACCESS: Penable=1.
- ACCESS->SETUP: Pselx!=0 and Penable=0 (back-to-back transfer).
- ACCESS->IDLE: Pselx=0.
- Any other input combination: go to IDLE.
REQ-013 SHALL have zero wait states; every transfer is exactly one setup cycle plus one access cycle.
REQ-014 SHALL form the word index from Paddr[log2(DEPTH)+1:2].
- Paddr[1:0] and all upper address bits are ignored.
- Addresses wrap within DEPTH.
REQ-015 SHALL write Pwdata into word[index] of the selected slot at the ACCESS-cycle edge when all of these hold: Pwrite=1, Penable=1, Pselx one-hot, FSM in SETUP.
REQ-016 SHALL handle reads as follows.
- Load Prdata at the SETUP-cycle edge, from word[index] of the selected slot, when Pwrite=0 and Pselx is one-hot.
- Prdata is therefore valid throughout the access phase.
REQ-017 SHALL hold Prdata at its last value in all other cycles.
REQ-018 SHALL load Prdata with 0 for a read setup whose Pselx is not one-hot.
REQ-019 SHALL keep slots independent; a write to one slot never alters another slot.
REQ-020 SHALL set Perr on any of these, and keep it set until reset:
- Penable=1 while the FSM is IDLE.
- Pselx, Paddr, Pwrite or Pwdata changed between SETUP and ACCESS.
- Pselx non-zero and not one-hot.
REQ-021 SHALL perform no memory write in a cycle that raises Perr.
REQ-022 SHALL apply write before read ordering: a read of an address written in the immediately preceding transfer returns the new data.

Reset
REQ-023 SHALL, on Presetn low, immediately and asynchronously set:
- FSM to IDLE;
- Prdata to 0;
- Perr to 0;
- every memory word to 0.
REQ-024 SHALL abort a transfer in progress at reset, with no write committed.
REQ-025 SHALL honour the first SETUP on the first rising Pclk edge after Presetn deasserts.

Structure
REQ-026 SHALL take from a shared package apb_pkg:
- the FSM state enum (IDLE, SETUP, ACCESS);
- defaults NUM_SLV=4 and DEPTH=16;
- the DATA_W=32 and ADDR_W=32 constants.
REQ-027 SHALL instantiate one sub-module, apb_slot_mem, once per slot.
- apb_slot_mem is a DEPTH x 32 register file with an async reset, a write enable and a read port.

Verification
REQ-028 SHALL cover write then read on one slot.
- Write Pselx=4'b0010, Paddr=0x8, Pwdata=0xDEADBEEF.
- Then read the same address.
- Required: Prdata=0xDEADBEEF during the access phase; Perr=0.
REQ-029 SHALL cover slot isolation.
- After REQ-028, read Pselx=4'b0001 at Paddr=0x8.
- Required: Prdata=0.
REQ-030 SHALL cover address wrap.
- Write 0x12345678 to slot 2 at Paddr=0x40.
- Read slot 2 at Paddr=0x0.
- Required: Prdata=0x12345678.
REQ-031 SHALL cover a non-one-hot select.
- Write with Pselx=4'b0011, Paddr=0x4, Pwdata=0xA5A5A5A5.
- Required: Perr=1.
- Required: a subsequent read of both slot 0 and slot 1 at 0x4 returns 0.
REQ-032 SHALL cover a protocol violation.
- Assert Penable=1 with no preceding setup.
- Required: Perr=1 next cycle, and it stays 1 until Presetn is pulsed low.
REQ-033 SHALL cover reset mid-transfer.
- Assert Presetn=0 during the access phase of a write of 0xCAFEF00D.
- Required: Prdata=0 and Perr=0 at once.
- Required: a later read of that address returns 0.
